// File: rtl/rx_clock_div_align.sv
// RX word clock divider: divides the recovered bit clock into pclk plus a symbol
// strobe, realigning word phase on commas and tracking symbol lock.
// Optional status outputs (realign_cnt, lock_loss) are built when RX_ALIGN_STATUS_EN is defined.
module rx_clock_div_align #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOCK_HITS = 3,
  parameter int unsigned LOCK_MISS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div_ratio,
  input  logic             realign_en,
  input  logic             comma_det,
  output logic             pclk,
  output logic             word_strobe,
  output logic             locked
`ifdef RX_ALIGN_STATUS_EN
  ,
  output logic [7:0]       realign_cnt,
  output logic             lock_loss
`endif
);

  localparam logic [0:0] STATE_UNLOCKED = 1'b0;
  localparam logic [0:0] STATE_LOCKED   = 1'b1;
  localparam logic [3:0] HITS = 4'(LOCK_HITS);
  localparam logic [3:0] MISS = 4'(LOCK_MISS);

  logic [0:0]       state, state_next;
  logic [WIDTH-1:0] bit_cnt, cnt_next, step, ratio, half, last;
  logic [3:0]       hit_cnt, hit_next, hit_inc;
  logic [3:0]       miss_cnt, miss_next, miss_inc;
  logic             aligned, misaligned, realign;

  always_comb begin
    ratio      = (div_ratio < WIDTH'(2)) ? WIDTH'(2) : div_ratio;
    half       = ratio >> 1;
    last       = ratio - 1'b1;
    aligned    = comma_det && (bit_cnt == last);
    misaligned = comma_det && !aligned;
    // >= rather than == so a lowered div_ratio wraps immediately
    step       = (bit_cnt >= last) ? '0 : bit_cnt + 1'b1;
    hit_inc    = (hit_cnt == '1) ? hit_cnt : hit_cnt + 1'b1;
    miss_inc   = (miss_cnt == '1) ? miss_cnt : miss_cnt + 1'b1;
    state_next = state;
    hit_next   = hit_cnt;
    miss_next  = miss_cnt;
    realign    = 1'b0;

    case (state)
      STATE_UNLOCKED: begin
        if (aligned) begin
          hit_next = hit_inc;
          if (hit_inc >= HITS) begin
            state_next = STATE_LOCKED;
            miss_next  = '0;
          end
        end else if (misaligned) begin
          if (realign_en) begin
            realign  = 1'b1;
            hit_next = 4'd1;
            if (LOCK_HITS == 1) begin
              state_next = STATE_LOCKED;
              miss_next  = '0;
            end
          end else begin
            hit_next = '0;
          end
        end
      end
      default: begin
        if (aligned) begin
          miss_next = '0;
        end else if (misaligned) begin
          miss_next = miss_inc;
          if (miss_inc >= MISS) begin
            state_next = STATE_UNLOCKED;
            miss_next  = '0;
            hit_next   = '0;
            if (realign_en) begin
              realign  = 1'b1;
              hit_next = 4'd1;
            end
          end
        end
      end
    endcase

    cnt_next = realign ? '0 : step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      pclk        <= 1'b0;
      word_strobe <= 1'b0;
      locked      <= 1'b0;
      state       <= STATE_UNLOCKED;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      bit_cnt     <= cnt_next;
      word_strobe <= (cnt_next == '0);
      if (cnt_next == '0)
        pclk <= 1'b1;
      else if (cnt_next == half)
        pclk <= 1'b0;
      locked      <= (state_next == STATE_LOCKED);
      state       <= state_next;
      hit_cnt     <= hit_next;
      miss_cnt    <= miss_next;
    end
  end

`ifdef RX_ALIGN_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      realign_cnt <= '0;
      lock_loss   <= 1'b0;
    end else begin
      if (realign && realign_cnt != '1)
        realign_cnt <= realign_cnt + 1'b1;
      lock_loss <= (state == STATE_LOCKED) && (state_next == STATE_UNLOCKED);
    end
  end
`endif

endmodule

// File: tb/tb_rx_clock_div_align.sv
// Directed bench for rx_clock_div_align: free run, realign/lock, lock loss,
// odd and changed ratios, disabled realign, and mid-symbol reset.
module tb_rx_clock_div_align;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] div_ratio = 8'd10;
  logic       realign_en = 1'b0;
  logic       comma_det = 1'b0;
  logic       pclk, word_strobe, locked;
`ifdef RX_ALIGN_STATUS_EN
  logic [7:0] realign_cnt;
  logic       lock_loss;
`endif
  int checks = 0;
  int failures = 0;

  rx_clock_div_align #(.WIDTH(8), .LOCK_HITS(3), .LOCK_MISS(4)) dut (
    .clk(clk), .rst(rst), .div_ratio(div_ratio), .realign_en(realign_en),
    .comma_det(comma_det), .pclk(pclk), .word_strobe(word_strobe), .locked(locked)
`ifdef RX_ALIGN_STATUS_EN
    , .realign_cnt(realign_cnt), .lock_loss(lock_loss)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic comma_tick();
    comma_det = 1'b1;
    tick(1);
    comma_det = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a posedge with bit_cnt == 0.
  task automatic do_reset(input logic [7:0] ratio, input logic ren);
    rst = 1'b1;
    div_ratio = ratio;
    realign_en = ren;
    comma_det = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'd10, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({pclk, word_strobe, locked} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000", {pclk, word_strobe, locked});
    end
`ifdef RX_ALIGN_STATUS_EN
    checks++;
    if (realign_cnt !== 8'd0 || lock_loss !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got cnt=%0d loss=%b want 0/0", realign_cnt, lock_loss);
    end
`endif
  endtask

  task automatic test_free_run();
    do_reset(8'd10, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      checks++;
      if (word_strobe !== (k % 10 == 0) || pclk !== (k >= 10 && k % 10 < 5) || locked !== 1'b0) begin
        failures++;
        $display("FAIL free_run k=%0d got s=%b p=%b l=%b want s=%b p=%b l=0", k,
                 word_strobe, pclk, locked, k % 10 == 0, k >= 10 && k % 10 < 5);
      end
    end
  endtask

  task automatic test_realign_lock();
    do_reset(8'd10, 1'b1);
    tick(3);
    comma_tick();   // misaligned at c=3 -> realign
    checks++;
    if (word_strobe !== 1'b1 || pclk !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL realign_short got s=%b p=%b l=%b want s=1 p=1 l=0", word_strobe, pclk, locked);
    end
    tick(9);
    comma_tick();   // aligned, hit 2
    checks++;
    if (word_strobe !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL realign_hit2 got s=%b l=%b want s=1 l=0", word_strobe, locked);
    end
    tick(9);
    comma_tick();   // aligned, hit 3
    checks++;
    if (word_strobe !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL realign_lock got s=%b l=%b want s=1 l=1", word_strobe, locked);
    end
`ifdef RX_ALIGN_STATUS_EN
    checks++;
    if (realign_cnt !== 8'd1) begin
      failures++;
      $display("FAIL realign_cnt1 got=%0d want=1", realign_cnt);
    end
`endif
  endtask

  // Continues from test_realign_lock: locked, bit_cnt == 0.
  task automatic test_lock_loss();
    tick(6);
    for (int i = 0; i < 3; i++) begin
      comma_tick();   // c=6 misaligned
      checks++;
      if (locked !== 1'b1 || word_strobe !== 1'b0) begin
        failures++;
        $display("FAIL miss_hold%0d got l=%b s=%b want l=1 s=0", i, locked, word_strobe);
      end
      tick(9);
    end
    tick(3);
    comma_tick();     // aligned, clears miss count
    checks++;
    if (locked !== 1'b1 || word_strobe !== 1'b1) begin
      failures++;
      $display("FAIL miss_clear got l=%b s=%b want l=1 s=1", locked, word_strobe);
    end
    tick(6);
    for (int i = 0; i < 3; i++) begin
      comma_tick();
      checks++;
      if (locked !== 1'b1) begin
        failures++;
        $display("FAIL miss_after_clear%0d got l=%b want l=1", i, locked);
      end
      tick(9);
    end
    comma_tick();     // 4th consecutive miss -> unlock and realign
    checks++;
    if (locked !== 1'b0 || word_strobe !== 1'b1 || pclk !== 1'b1) begin
      failures++;
      $display("FAIL unlock_realign got l=%b s=%b p=%b want l=0 s=1 p=1", locked, word_strobe, pclk);
    end
`ifdef RX_ALIGN_STATUS_EN
    checks++;
    if (lock_loss !== 1'b1 || realign_cnt !== 8'd2) begin
      failures++;
      $display("FAIL loss_pulse got loss=%b cnt=%0d want 1/2", lock_loss, realign_cnt);
    end
`endif
    tick(1);
    checks++;
    if (word_strobe !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL after_unlock got s=%b l=%b want s=0 l=0", word_strobe, locked);
    end
`ifdef RX_ALIGN_STATUS_EN
    checks++;
    if (lock_loss !== 1'b0) begin
      failures++;
      $display("FAIL loss_one_cycle got=%b want=0", lock_loss);
    end
`endif
  endtask

  task automatic test_odd_ratio();
    do_reset(8'd9, 1'b0);
    for (int k = 1; k <= 27; k++) begin
      tick(1);
      checks++;
      if (word_strobe !== (k % 9 == 0) || pclk !== (k >= 9 && k % 9 < 4)) begin
        failures++;
        $display("FAIL odd_r9 k=%0d got s=%b p=%b want s=%b p=%b", k, word_strobe, pclk,
                 k % 9 == 0, k >= 9 && k % 9 < 4);
      end
    end
    tick(7);            // bit_cnt == 7
    div_ratio = 8'd6;
    tick(1);
    checks++;
    if (word_strobe !== 1'b1 || pclk !== 1'b1) begin
      failures++;
      $display("FAIL ratio_drop_wrap got s=%b p=%b want s=1 p=1", word_strobe, pclk);
    end
    for (int j = 1; j <= 12; j++) begin
      tick(1);
      checks++;
      if (word_strobe !== (j % 6 == 0) || pclk !== (j % 6 < 3)) begin
        failures++;
        $display("FAIL r6 j=%0d got s=%b p=%b want s=%b p=%b", j, word_strobe, pclk,
                 j % 6 == 0, j % 6 < 3);
      end
    end
  endtask

  task automatic test_no_realign();
    do_reset(8'd10, 1'b0);
    tick(3);
    comma_tick();     // misaligned, no shift
    checks++;
    if (word_strobe !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL noshift_comma got s=%b l=%b want 0/0", word_strobe, locked);
    end
    tick(5);
    tick(1);
    checks++;
    if (word_strobe !== 1'b1) begin
      failures++;
      $display("FAIL noshift_phase got s=%b want 1", word_strobe);
    end
    tick(9);
    comma_tick();     // aligned, hit 1
    tick(3);
    comma_tick();     // misaligned, hit back to 0
    tick(5);
    comma_tick();     // aligned, hit 1
    tick(9);
    comma_tick();     // aligned, hit 2
    checks++;
    if (locked !== 1'b0 || word_strobe !== 1'b1) begin
      failures++;
      $display("FAIL hit_cleared got l=%b s=%b want l=0 s=1", locked, word_strobe);
    end
    tick(9);
    comma_tick();     // aligned, hit 3
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL hit_relock got l=%b want 1", locked);
    end
    do_reset(8'd1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checks++;
      if (word_strobe !== (k % 2 == 0) || pclk !== (k % 2 == 0)) begin
        failures++;
        $display("FAIL ratio1 k=%0d got s=%b p=%b want %b", k, word_strobe, pclk, k % 2 == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(8'd10, 1'b1);
    tick(2);
    comma_tick();     // realign at c=2
    tick(9);
    comma_tick();
    tick(9);
    comma_tick();     // locked
    tick(3);          // bit_cnt == 3, pclk high
    checks++;
    if (locked !== 1'b1 || pclk !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got l=%b p=%b want 1/1", locked, pclk);
    end
    tick(2);          // bit_cnt == 5
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({pclk, word_strobe, locked} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset got=%b want=000", {pclk, word_strobe, locked});
    end
`ifdef RX_ALIGN_STATUS_EN
    checks++;
    if (realign_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_cnt got=%0d want=0", realign_cnt);
    end
`endif
    tick(1);
    rst = 1'b0;
    tick(1);
    checks++;
    if (word_strobe !== 1'b0 || pclk !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL post_release got s=%b p=%b l=%b want 000", word_strobe, pclk, locked);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_realign_lock();
    test_lock_loss();
    test_odd_ratio();
    test_no_realign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/rx_clock_div_align.md
Name: rx_clock_div_align

Overview:
- Receive-side counterpart of the TX PHY clock divider.
- Divides the recovered bit clock by div_ratio to produce the RX parallel clock (pclk) and a one-cycle word-boundary strobe.
- Uses comma detections from the deserializer to realign the word phase and to track symbol lock.
- Sits between the CDR/deserializer and the RX elastic buffer and decoder.

Parameters:
- WIDTH, 8: width of div_ratio and of the internal bit counter.
- LOCK_HITS, 3: consecutive aligned commas needed to enter LOCKED. Range 1..15.
- LOCK_MISS, 4: consecutive misaligned commas in LOCKED that force UNLOCKED. Range 1..15.

Ports:
- clk  input  1  recovered bit clock (one cycle per serial bit)
- rst  input  1  asynchronous, active-high reset
- div_ratio  input  WIDTH  bits per symbol (10 for 8b/10b); static outside reset
- realign_en  input  1  1 = comma may shift word phase while UNLOCKED
- comma_det  input  1  one-cycle pulse in the cycle the last bit of a comma is sampled
- pclk  output  1  divided parallel clock, registered
- word_strobe  output  1  one-clk pulse at each symbol start, registered
- locked  output  1  symbol lock status, registered

Behaviour:
- Reset (async, rst=1):
  - bit_cnt=0, pclk=0, word_strobe=0, locked=0.
  - State=UNLOCKED; hit_cnt=0, miss_cnt=0.
  - Reset asserted mid-symbol aborts immediately. The first symbol after release starts at bit_cnt=0 with no strobe.
- Effective ratio R:
  - R = max(div_ratio, 2).
  - H = R>>1. Odd R gives a high phase of H cycles and a low phase of R-H cycles.
- Counter:
  - Normal step: bit_cnt_next = (bit_cnt >= R-1) ? 0 : bit_cnt+1.
  - The >= compare makes a lowered div_ratio wrap at once.
- Registered outputs, computed from bit_cnt_next:
  - word_strobe = (bit_cnt_next==0).
  - pclk = 1 when bit_cnt_next==0; pclk = 0 when bit_cnt_next==H; otherwise pclk holds.
  - pclk rises together with word_strobe.
- Comma classification at cycle t, with counter value c:
  - aligned if c==R-1; misaligned otherwise.
- Realign action: force bit_cnt_next=0. At t+1 bit_cnt=0, pclk=1, word_strobe=1, so the shortened symbol is c+1 cycles.
- State UNLOCKED:
  - Aligned comma: hit_cnt++. When hit_cnt reaches LOCK_HITS, go to LOCKED, set locked=1 at t+1, clear miss_cnt.
  - Misaligned comma with realign_en=1: realign and set hit_cnt=1. If LOCK_HITS==1, go to LOCKED directly.
  - Misaligned comma with realign_en=0: no phase change, hit_cnt=0.
- State LOCKED:
  - Aligned comma: miss_cnt=0.
  - Misaligned comma: miss_cnt++. On reaching LOCK_MISS:
    - go to UNLOCKED and set locked=0 at t+1;
    - set hit_cnt=0 and miss_cnt=0;
    - if realign_en=1, realign on this same comma and set hit_cnt=1.
  - A phase change never occurs in LOCKED without the LOCK_MISS threshold.
- comma_det is ignored during reset.
- Back-to-back comma pulses are each classified independently.
- Counters saturate and never wrap.

Optional Feature:
- Macro RX_ALIGN_STATUS_EN.
- Defined:
  - adds output realign_cnt (8 bits), reset to 0;
  - increments by 1 at each realign action and saturates at 255;
  - adds output lock_loss (1 bit), a one-clk registered pulse on each LOCKED->UNLOCKED transition.
- Undefined: neither port exists and there is no related logic. Core behaviour is identical in both builds.

Test Plan:
1. Free run, R=10, no commas: after rst drops, word_strobe pulses every 10 clk; pclk high 5 / low 5; locked=0.
2. R=10, realign_en=1, comma at c=3, then commas every 10 clk: realign at t+1 (short symbol of 4 clk); locked=1 one cycle after the 3rd aligned-counting comma.
3. Locked R=10, then 3 misaligned commas (c=6) then 1 aligned: locked stays 1 and miss_cnt clears. Then 4 consecutive misaligned commas: locked=0 and the phase is realigned on the 4th.
4. R=9 (odd): pclk high 4 / low 5, strobe every 9 clk. Change div_ratio to 6 while bit_cnt=7: wrap on the next cycle, then period 6.
5. realign_en=0, UNLOCKED, misaligned commas: no phase shift, hit_cnt stays 0, locked stays 0. div_ratio=1 behaves as R=2.
6. Assert rst mid-symbol in LOCKED (bit_cnt=5): all outputs 0 immediately. With RX_ALIGN_STATUS_EN defined, realign_cnt=0 and is incremented in scenario 2.
